// File: rtl/scaler_readout_seq_pkg.sv
// scaler_readout_seq_pkg: shared FSM encoding and frame geometry
package scaler_readout_seq_pkg;
  localparam int AW = 5;
  localparam int FRAME_LEN = 33;
  localparam int HDR_IDX = 0;
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, HDR, OUT, DONE} state_e;
endpackage

// File: rtl/scaler_tick_div.sv
// scaler_tick_div: counts khz ticks while enabled and requests a frame every PERIOD ticks
module scaler_tick_div #(
  parameter int PERIOD = 100
) (
  input  logic clk33_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic tick_i,
  output logic req_o
);
  logic [7:0] cnt_q, cnt_d;
  logic wrap;
  assign wrap = cnt_q == 8'(PERIOD - 1);
  assign req_o = en_i & tick_i & wrap;
  assign cnt_d = !en_i ? '0 : !tick_i ? cnt_q : wrap ? '0 : cnt_q + 8'd1;
  always_ff @(posedge clk33_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/scaler_readout_seq.sv
// scaler_readout_seq: reads a reference-pulse header plus 32 scaler words into a ready/valid stream
module scaler_readout_seq
  import scaler_readout_seq_pkg::*;
#(
  parameter int AUTO_PERIOD = 100,
  parameter int NWORDS = 32
) (
  input  logic          clk33_i,
  input  logic          rst_n_i,
  input  logic          khz_tick_i,
  input  logic          auto_en_i,
  input  logic          host_req_i,
  output logic [AW-1:0] scal_addr_o,
  output logic          scal_rd_o,
  input  logic [15:0]   scal_dat_i,
  input  logic [15:0]   refpulse_cnt_i,
  output logic [15:0]   dat_o,
  output logic          dat_valid_o,
  input  logic          dat_ready_i,
  output logic          sof_o,
  output logic          eof_o,
  output logic          busy_o,
  output logic          overrun_o
);
  localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);
  localparam logic [AW-1:0] HDR_ADDR = AW'(HDR_IDX);
  logic [1:0] rst_sync_q;
  logic rst_n;
  state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [15:0] hdr_q, hdr_d, scal_q, scal_d;
  logic pending_q, pending_d, overrun_q, overrun_d;
  logic auto_req, req, go;
  always_ff @(posedge clk33_i or negedge rst_n_i)
    if (!rst_n_i) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  scaler_tick_div #(.PERIOD(AUTO_PERIOD)) u_div (
    .clk33_i(clk33_i),
    .rst_n_i(rst_n),
    .en_i(auto_en_i),
    .tick_i(khz_tick_i),
    .req_o(auto_req)
  );
  assign req = host_req_i | auto_req;
  assign go = (state_q == IDLE) & (pending_q | req);
  assign pending_d = go ? pending_q & req : pending_q | req;
  assign overrun_d = overrun_q | (pending_q & req);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    hdr_d = hdr_q;
    scal_d = scal_q;
    case (state_q)
      IDLE: if (go) begin state_d = ISSUE; idx_d = '0; end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        scal_d = scal_dat_i;
        hdr_d = idx_q == HDR_ADDR ? refpulse_cnt_i : hdr_q;
        state_d = idx_q == HDR_ADDR ? HDR : OUT;
      end
      HDR: state_d = dat_ready_i ? OUT : HDR;
      OUT: if (dat_ready_i) begin
        state_d = idx_q == LAST ? DONE : ISSUE;
        idx_d = idx_q == LAST ? idx_q : idx_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk33_i or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      hdr_q <= '0;
      scal_q <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      hdr_q <= hdr_d;
      scal_q <= scal_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  assign scal_addr_o = idx_q;
  assign scal_rd_o = state_q == ISSUE;
  assign dat_valid_o = (state_q == HDR) | (state_q == OUT);
  assign dat_o = state_q == HDR ? hdr_q : state_q == OUT ? scal_q : '0;
  assign sof_o = state_q == HDR;
  assign eof_o = (state_q == OUT) & (idx_q == LAST);
  assign busy_o = state_q != IDLE;
  assign overrun_o = overrun_q;
endmodule

// File: doc/scaler_readout_seq.md
SCALER_READOUT_SEQ -- requirements
Module: scaler_readout_seq

Interface
REQ-001 Parameter AUTO_PERIOD, default 100: khz ticks between automatic frames, legal range 1..255.
REQ-002 Parameter NWORDS, default 32: scaler addresses per frame, fixed at 32.
REQ-003 clk33_i  in  1  33 MHz system clock; the only clock.
REQ-004 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 khz_tick_i  in  1  one-cycle 1 kHz scaler-update strobe.
REQ-006 auto_en_i  in  1  enables periodic automatic frames.
REQ-007 host_req_i  in  1  one-cycle host request for a frame.
REQ-008 scal_addr_o  out  5  scaler RAM address to the scaler block.
REQ-009 scal_rd_o  out  1  scaler read strobe to the scaler block.
REQ-010 scal_dat_i  in  16  scaler data, valid 1 cycle after the address.
REQ-011 refpulse_cnt_i  in  16  reference-pulse count, valid 1 cycle after the address.
REQ-012 dat_o  out  16  output word.
REQ-013 dat_valid_o  out  1  dat_o valid.
REQ-014 dat_ready_i  in  1  consumer accepts dat_o.
REQ-015 sof_o / eof_o  out  1 each  first / last word of a frame, qualified by dat_valid_o.
REQ-016 busy_o  out  1  frame in progress.
REQ-017 overrun_o  out  1  sticky flag: a request was dropped.

Function
REQ-018 Frame format SHALL be 33 words: the header (refpulse_cnt_i sampled on the address-0 read), then scaler words for addresses 0..31 in ascending order.
REQ-019 The state machine SHALL have states IDLE, ISSUE, CAPTURE, HDR, OUT and DONE.
REQ-020 IDLE -> ISSUE occurs when a request is pending; busy_o SHALL be 1 in every state except IDLE.
REQ-021 In ISSUE, the block SHALL drive scal_addr_o=idx and scal_rd_o=1 for exactly one cycle, then go to CAPTURE.
REQ-022 In CAPTURE, the block SHALL register scal_dat_i and, when idx=0, also refpulse_cnt_i.
- Next state is HDR when idx=0, otherwise OUT.
REQ-023 In HDR and OUT, dat_valid_o SHALL be 1 and dat_o, sof_o and eof_o SHALL be held stable until dat_ready_i=1.
- HDR then goes to OUT.
- OUT goes to ISSUE with idx+1, or to DONE when idx=31.
REQ-024 sof_o SHALL be 1 only on the header word; eof_o SHALL be 1 only on the address-31 word.
REQ-025 scal_rd_o SHALL pulse exactly once per address per frame, including under back-pressure.
- scal_addr_o SHALL hold its last value when scal_rd_o=0.
REQ-026 DONE SHALL last one cycle and then return to IDLE.
REQ-027 Auto divider: an 8-bit counter SHALL increment on each khz_tick_i while auto_en_i=1.
- On reaching AUTO_PERIOD-1 it wraps to 0 and raises an auto request.
- auto_en_i=0 SHALL clear the counter.
REQ-028 Request latch: host_req_i or an auto request SHALL set a single pending bit.
- Simultaneous host and auto requests SHALL produce one frame.
REQ-029 The pending bit SHALL clear on the IDLE -> ISSUE transition.
- A request arriving in that same cycle SHALL remain pending.
REQ-030 A request arriving while pending is already 1 SHALL set overrun_o.
- overrun_o is cleared only by reset.
REQ-031 Minimum pipelined throughput SHALL be one word per 3 cycles.
REQ-032 Latency from a request in IDLE to the header valid SHALL be 3 cycles.

Reset
REQ-033 While rst_n_i=0, all registers SHALL clear asynchronously:
- state=IDLE, idx=0, pending=0, divider=0;
- dat_o=0, dat_valid_o=0, sof_o=0, eof_o=0;
- scal_rd_o=0, scal_addr_o=0, busy_o=0, overrun_o=0.
REQ-034 Reset mid-frame SHALL abandon the frame without asserting eof_o.
REQ-035 Reset deassertion SHALL be synchronised to clk33_i before use.

Structure
REQ-036 A shared package SHALL hold the state encoding, the frame length constant (33), the header index and the address width (5).
REQ-037 The auto divider SHALL be one sub-module, scaler_tick_div, with ports clk33_i, rst_n_i, en_i, tick_i and req_o.

Verification
REQ-038 The bench SHALL cover these scenarios:
- Host pulse, dat_ready_i=1, refpulse=0x0ABC, scaler n=0x0100+n -> 33 words: 0x0ABC (sof), 0x0100..0x011F (eof on 0x011F); each address read once.
- Random dat_ready_i (50% duty) -> identical 33-word frame; exactly 32 scal_rd_o pulses; dat_o stable while stalled.
- AUTO_PERIOD=3, auto_en_i=1, 10 khz ticks -> frames start after ticks 3, 6 and 9.
- Host and auto request in the same cycle -> one frame, overrun_o=0; a further two requests during that frame -> overrun_o=1 and one extra frame.
- rst_n_i low at word 10 -> all outputs 0 immediately; the next host request yields a full frame starting with sof.
- auto_en_i dropped after 2 ticks with AUTO_PERIOD=3 -> no frame; after re-enable, the first frame comes 3 ticks later.
